pmem_arbiter: RTL and testbench
===============================

# pmem_arbiter

Arbitrates the instruction cache and data cache line requests onto the single burst physical-memory port of `mp4`. It sits between the two caches and the `pmem_*` top-level ports. Each 256-bit cache line is serialized to, or assembled from, four 64-bit bursts. Exactly one line transaction is outstanding at a time.

## Interface
- `LINE_W`, default 256: cache line width in bits.
- `BEAT_W`, default 64: burst beat width in bits. `BEATS = LINE_W/BEAT_W = 4`.
- `clk`  in  1  : the single clock. All state updates on the rising edge.
- `rst`  in  1  : reset, synchronous, active-high.
- `icache_pmem_read`  in  1  : instruction line read request. Held until `icache_pmem_resp`.
- `icache_pmem_address`  in  32  : line address. Bits [4:0] are zero.
- `icache_pmem_rdata`  out  LINE_W  : assembled line.
- `icache_pmem_resp`  out  1  : one-cycle completion pulse.
- `dcache_pmem_read`  in  1  : data line read request.
- `dcache_pmem_write`  in  1  : data line writeback request. Never asserted together with read.
- `dcache_pmem_address`  in  32  : line address. Bits [4:0] are zero.
- `dcache_pmem_wdata`  in  LINE_W  : writeback line. Stable while the request is held.
- `dcache_pmem_rdata`  out  LINE_W  : assembled line.
- `dcache_pmem_resp`  out  1  : one-cycle completion pulse.
- `pmem_read`, `pmem_write`  out  1  : burst command to memory.
- `pmem_address`  out  32  : line address of the active transaction.
- `pmem_wdata`  out  BEAT_W  : current write beat.
- `pmem_rdata`  in  BEAT_W  : current read beat. Valid when `pmem_resp` is high.
- `pmem_resp`  in  1  : beat accepted or returned. High for exactly 4 cycles per burst; those cycles need not be consecutive.

## Operation
- FSM states: IDLE, I_READ, D_READ, D_WRITE, DONE_I, DONE_D.
- IDLE: requests are sampled only in this state.
  - If only one cache requests, that cache is granted.
  - If both request, the grant goes to the cache not served last. The `last_d` flag resets to 0, so the dcache wins the first tie.
- On grant:
  - `pmem_address` and command are registered from the granted cache.
  - The beat counter `beat` is cleared.
  - The state moves to I_READ, D_READ or D_WRITE.
- Read states: on each `pmem_resp`, `pmem_rdata` is stored into line slice `[beat*64 +: 64]` and `beat` increments. Beat 0 is the least significant slice.
- D_WRITE: `pmem_wdata` is `dcache_pmem_wdata[beat*64 +: 64]`, selected combinationally from `beat`. `beat` increments on each `pmem_resp`.
- When `pmem_resp` arrives with `beat == 3`:
  - Go to DONE_I or DONE_D.
  - Deassert `pmem_read`/`pmem_write` on that edge.
  - Update `last_d`.
- DONE_x:
  - Assert the matching `*_resp` for exactly one cycle.
  - Drive `*_rdata` from the line buffer. It stays valid until the next grant overwrites the buffer.
  - The next state is IDLE unconditionally.
- Requests arriving outside IDLE wait; they are never dropped.
- A cache must deassert its request in the cycle after seeing `resp`. The DONE→IDLE gap guarantees that no stale re-grant occurs.
- `pmem_read`/`pmem_write` are registered outputs and never both high. `pmem_resp` outside an active burst is ignored.
- A 2-bit `beat` wraps from 3 to 0 only by leaving the burst state.

## Timing
- Reset values:
  - State is IDLE; `beat`, `last_d` and the line buffer are 0.
  - Outputs `pmem_read`, `pmem_write`, `pmem_address`, `pmem_wdata`, both `*_resp` and both `*_rdata` are all 0.
- Reset mid-burst: on the next edge, return to IDLE with all outputs 0. The partial line is discarded and no `resp` is issued.
- Request is accepted at edge N (state IDLE, request high). `pmem_read`/`pmem_write` is high from cycle N+1.
- With back-to-back memory, `pmem_resp` is high in cycles N+1..N+4 and `*_resp` pulses in cycle N+5.
- Minimum spacing between grants is 6 cycles: grant, 4 beats, DONE, then IDLE.
- `pmem_wdata` changes in the cycle after each accepted beat.

## Structure
- `rv32i_types` package additions:
  - `pmem_arb_state_t` enum.
  - Constants `LINE_W = 256`, `BEAT_W = 64`, `PMEM_BEATS = 4`.
- No sub-module: one FSM plus a line buffer, beat counter and `last_d` flag.
- Instantiated once inside `mp4`. Its `pmem_*` ports connect directly to the top-level ports.

## Test plan
- Icache read of 0x0000_0040; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 → `icache_pmem_rdata = {44..,33..,22..,11..}`. `icache_pmem_resp` high for 1 cycle, 5 cycles after the grant.
- Dcache write of 0x0000_1000 with wdata = {D,C,B,A} beats → `pmem_wdata` shows A, B, C, D on successive `pmem_resp` cycles; `dcache_pmem_resp` pulses once; `pmem_read` stays 0.
- Both caches request in the same cycle after reset → dcache is served first, then icache. A second simultaneous pair after that is served icache first.
- Memory inserts 3 idle cycles between beats 1 and 2 → `beat` holds, the line is assembled correctly, and `resp` is delayed by exactly 3 cycles.
- `rst` asserted after beat 2 of an icache read → next cycle all outputs are 0 and no `resp` is issued. The request is re-issued after reset and completes normally.
- Dcache read raised during an active icache burst → granted only after DONE_I→IDLE, with the dcache burst starting 2 cycles after `icache_pmem_resp`.

Source files
------------

// File: rtl/pmem_arbiter_pkg.sv
// Shared types and constants for the icache/dcache to physical-memory burst arbiter.
// A cache line is moved as PMEM_BEATS beats of BEAT_W bits, beat 0 least significant.
package pmem_arbiter_pkg;

  localparam int LINE_W     = 256;
  localparam int BEAT_W     = 64;
  localparam int PMEM_BEATS = LINE_W / BEAT_W;
  localparam int BEAT_IDX_W = $clog2(PMEM_BEATS);

  localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(PMEM_BEATS - 1);

  typedef enum logic [2:0] {
    IDLE,
    I_READ,
    D_READ,
    D_WRITE,
    DONE_I,
    DONE_D
  } pmem_arb_state_t;

  // Bit offset of a beat inside the line.
  function automatic int beat_lsb(input logic [BEAT_IDX_W-1:0] idx);
    return int'(idx) * BEAT_W;
  endfunction

endpackage

// File: rtl/pmem_arbiter_if.sv
// Bundle of the two cache-side line ports and the burst memory port.
// slave is the arbiter's view; master is the view of the caches plus memory.
interface pmem_arbiter_if #(
  parameter int LINE_W = pmem_arbiter_pkg::LINE_W,
  parameter int BEAT_W = pmem_arbiter_pkg::BEAT_W
);

  logic              icache_pmem_read;
  logic [31:0]       icache_pmem_address;
  logic [LINE_W-1:0] icache_pmem_rdata;
  logic              icache_pmem_resp;

  logic              dcache_pmem_read;
  logic              dcache_pmem_write;
  logic [31:0]       dcache_pmem_address;
  logic [LINE_W-1:0] dcache_pmem_wdata;
  logic [LINE_W-1:0] dcache_pmem_rdata;
  logic              dcache_pmem_resp;

  logic              pmem_read;
  logic              pmem_write;
  logic [31:0]       pmem_address;
  logic [BEAT_W-1:0] pmem_wdata;
  logic [BEAT_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport slave (
    input  icache_pmem_read, icache_pmem_address,
    output icache_pmem_rdata, icache_pmem_resp,
    input  dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
    output dcache_pmem_rdata, dcache_pmem_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport master (
    output icache_pmem_read, icache_pmem_address,
    input  icache_pmem_rdata, icache_pmem_resp,
    output dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
    input  dcache_pmem_rdata, dcache_pmem_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );

endinterface

// File: rtl/pmem_arbiter.sv
// Serializes icache/dcache line transactions onto one burst memory port,
// one line outstanding at a time, with round-robin resolution of simultaneous requests.
module pmem_arbiter
  import pmem_arbiter_pkg::*;
(
  input logic          clk,
  input logic          rst,
  pmem_arbiter_if.slave bus
);

  pmem_arb_state_t       state, state_nx;
  logic [BEAT_IDX_W-1:0] beat;
  logic                  last_d;
  logic [LINE_W-1:0]     line_buf;

  logic d_req, grant_i, grant_d;
  logic in_burst, reading, beat_ok, burst_done;

  assign d_req      = bus.dcache_pmem_read || bus.dcache_pmem_write;
  assign in_burst   = (state == I_READ) || (state == D_READ) || (state == D_WRITE);
  assign reading    = (state == I_READ) || (state == D_READ);
  assign beat_ok    = in_burst && bus.pmem_resp;
  assign burst_done = beat_ok && (beat == LAST_BEAT);

  // On a tie the cache not served last wins; last_d=0 after reset favours the dcache.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state == IDLE) begin
      if (d_req && (!bus.icache_pmem_read || !last_d)) begin
        grant_d = 1'b1;
      end else if (bus.icache_pmem_read) begin
        grant_i = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (grant_d)      state_nx = bus.dcache_pmem_write ? D_WRITE : D_READ;
        else if (grant_i) state_nx = I_READ;
      end
      I_READ:          if (burst_done) state_nx = DONE_I;
      D_READ, D_WRITE: if (burst_done) state_nx = DONE_D;
      DONE_I, DONE_D:  state_nx = IDLE;
      default:         state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.icache_pmem_resp  = (state == DONE_I);
    bus.dcache_pmem_resp  = (state == DONE_D);
    bus.icache_pmem_rdata = line_buf;
    bus.dcache_pmem_rdata = line_buf;
    bus.pmem_wdata        = '0;
    if (state == D_WRITE) begin
      bus.pmem_wdata = bus.dcache_pmem_wdata[beat_lsb(beat) +: BEAT_W];
    end
  end

  // The 2-bit beat counter rolls 3->0 on the final beat, exactly as the burst is left.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      beat             <= '0;
      last_d           <= 1'b0;
      line_buf         <= '0;
      bus.pmem_read    <= 1'b0;
      bus.pmem_write   <= 1'b0;
      bus.pmem_address <= '0;
    end else begin
      state <= state_nx;
      if (grant_d) begin
        beat             <= '0;
        bus.pmem_address <= bus.dcache_pmem_address;
        bus.pmem_read    <= bus.dcache_pmem_read;
        bus.pmem_write   <= bus.dcache_pmem_write;
      end else if (grant_i) begin
        beat             <= '0;
        bus.pmem_address <= bus.icache_pmem_address;
        bus.pmem_read    <= 1'b1;
        bus.pmem_write   <= 1'b0;
      end else if (beat_ok) begin
        beat <= beat + 1'b1;
        if (reading) begin
          line_buf[beat_lsb(beat) +: BEAT_W] <= bus.pmem_rdata;
        end
        if (burst_done) begin
          bus.pmem_read  <= 1'b0;
          bus.pmem_write <= 1'b0;
          last_d         <= (state != I_READ);
        end
      end
    end
  end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: a scoreboard of expected line completions and
// write beats is filled as requests are raised and drained as the DUT answers.
module tb_pmem_arbiter;
  import pmem_arbiter_pkg::*;

  typedef logic [LINE_W-1:0] w_t;
  typedef struct {
    bit is_d;
    bit has_data;
    w_t line;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  pmem_arbiter_if bus ();

  pmem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t              sb_q[$];
  logic [BEAT_W-1:0] wbeat_q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int cmd_cyc  = 0;
  int resp_cyc = 0;
  w_t mem_line;

  localparam logic [BEAT_W-1:0] B1 = 64'h1111_1111_1111_1111;
  localparam logic [BEAT_W-1:0] B2 = 64'h2222_2222_2222_2222;
  localparam logic [BEAT_W-1:0] B3 = 64'h3333_3333_3333_3333;
  localparam logic [BEAT_W-1:0] B4 = 64'h4444_4444_4444_4444;
  localparam logic [BEAT_W-1:0] WA = 64'hAAAA_0000_AAAA_0001;
  localparam logic [BEAT_W-1:0] WB = 64'hBBBB_0000_BBBB_0002;
  localparam logic [BEAT_W-1:0] WC = 64'hCCCC_0000_CCCC_0003;
  localparam logic [BEAT_W-1:0] WD = 64'hDDDD_0000_DDDD_0004;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input w_t obs, input w_t exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input bit is_d, input bit has_data, input w_t line);
    exp_t e;
    e.is_d     = is_d;
    e.has_data = has_data;
    e.line     = line;
    sb_q.push_back(e);
  endtask

  task automatic wait_cmd();
    int n = 0;
    while (!(bus.pmem_read || bus.pmem_write) && n < 20) begin
      step();
      n++;
    end
    cmd_cyc = cyc;
    chk("cmd_seen", w_t'(bus.pmem_read || bus.pmem_write), w_t'(1));
    chk("cmd_excl", w_t'(bus.pmem_read && bus.pmem_write), w_t'(0));
  endtask

  // Memory side: returns beats of mem_line (or accepts write beats), optionally
  // stalling for 'gap' cycles before beat 2.
  task automatic mem_burst(input int gap, input int nbeats);
    logic [BEAT_W-1:0] exp_w;
    for (int b = 0; b < nbeats; b++) begin
      if (b == 2) begin
        for (int g = 0; g < gap; g++) begin
          bus.pmem_resp = 1'b0;
          chk("cmd_hold", w_t'(bus.pmem_read || bus.pmem_write), w_t'(1));
          step();
        end
      end
      bus.pmem_resp  = 1'b1;
      bus.pmem_rdata = mem_line[b*BEAT_W +: BEAT_W];
      if (bus.pmem_write) begin
        chk("no_read_in_write", w_t'(bus.pmem_read), w_t'(0));
        if (wbeat_q.size() == 0) begin
          chk("wbeat_q_empty", w_t'(1), w_t'(0));
        end else begin
          exp_w = wbeat_q.pop_front();
          chk("pmem_wdata", w_t'(bus.pmem_wdata), w_t'(exp_w));
        end
      end
      step();
    end
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
  endtask

  task automatic wait_resp();
    int   n = 0;
    exp_t e;
    logic obs_d;
    while (!(bus.icache_pmem_resp || bus.dcache_pmem_resp) && n < 20) begin
      step();
      n++;
    end
    resp_cyc = cyc;
    chk("resp_seen", w_t'(bus.icache_pmem_resp || bus.dcache_pmem_resp), w_t'(1));
    chk("resp_excl", w_t'(bus.icache_pmem_resp && bus.dcache_pmem_resp), w_t'(0));
    chk("cmd_off_at_done", w_t'(bus.pmem_read || bus.pmem_write), w_t'(0));
    obs_d = bus.dcache_pmem_resp;
    if (sb_q.size() == 0) begin
      chk("sb_empty", w_t'(1), w_t'(0));
    end else begin
      e = sb_q.pop_front();
      chk("resp_src", w_t'(obs_d), w_t'(e.is_d));
      if (e.has_data) begin
        chk("rdata", e.is_d ? bus.dcache_pmem_rdata : bus.icache_pmem_rdata, e.line);
      end
    end
    step();
    chk("resp_pulse", w_t'(bus.icache_pmem_resp || bus.dcache_pmem_resp), w_t'(0));
    if (obs_d) begin
      bus.dcache_pmem_read  = 1'b0;
      bus.dcache_pmem_write = 1'b0;
    end else begin
      bus.icache_pmem_read = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    w_t l_a, l_b, l_c;
    l_a = {B4, B3, B2, B1};
    l_b = {B1, B3, B4, B2};
    l_c = {B2, B2, B4, B3};

    bus.icache_pmem_read    = 1'b0;
    bus.icache_pmem_address = '0;
    bus.dcache_pmem_read    = 1'b0;
    bus.dcache_pmem_write   = 1'b0;
    bus.dcache_pmem_address = '0;
    bus.dcache_pmem_wdata   = {WD, WC, WB, WA};
    bus.pmem_rdata          = '0;
    bus.pmem_resp           = 1'b0;

    // Reset state
    do_reset();
    chk("rst_pmem_read",  w_t'(bus.pmem_read),  w_t'(0));
    chk("rst_pmem_write", w_t'(bus.pmem_write), w_t'(0));
    chk("rst_pmem_addr",  w_t'(bus.pmem_address), w_t'(0));
    chk("rst_pmem_wdata", w_t'(bus.pmem_wdata), w_t'(0));
    chk("rst_i_resp",     w_t'(bus.icache_pmem_resp), w_t'(0));
    chk("rst_d_resp",     w_t'(bus.dcache_pmem_resp), w_t'(0));
    chk("rst_i_rdata",    bus.icache_pmem_rdata, w_t'(0));
    chk("rst_d_rdata",    bus.dcache_pmem_rdata, w_t'(0));

    // Stray pmem_resp while idle must be ignored
    bus.pmem_resp = 1'b1;
    step();
    bus.pmem_resp = 1'b0;
    chk("stray_resp_cmd", w_t'(bus.pmem_read || bus.pmem_write), w_t'(0));

    // Icache read, back-to-back memory
    bus.icache_pmem_read    = 1'b1;
    bus.icache_pmem_address = 32'h0000_0040;
    push_exp(1'b0, 1'b1, l_a);
    wait_cmd();
    chk("i_addr", w_t'(bus.pmem_address), w_t'(32'h0000_0040));
    chk("i_is_read", w_t'(bus.pmem_read), w_t'(1));
    mem_line = l_a;
    mem_burst(0, 4);
    wait_resp();
    chk("i_latency", w_t'(resp_cyc - cmd_cyc), w_t'(4));

    // Dcache writeback
    bus.dcache_pmem_write   = 1'b1;
    bus.dcache_pmem_address = 32'h0000_1000;
    bus.dcache_pmem_wdata   = {WD, WC, WB, WA};
    wbeat_q.push_back(WA);
    wbeat_q.push_back(WB);
    wbeat_q.push_back(WC);
    wbeat_q.push_back(WD);
    push_exp(1'b1, 1'b0, '0);
    wait_cmd();
    chk("w_addr", w_t'(bus.pmem_address), w_t'(32'h0000_1000));
    chk("w_is_write", w_t'(bus.pmem_write), w_t'(1));
    mem_line = '0;
    mem_burst(0, 4);
    chk("w_beats_used", w_t'(wbeat_q.size()), w_t'(0));
    wait_resp();

    // Simultaneous requests straight after reset: dcache first, then icache
    do_reset();
    bus.icache_pmem_read    = 1'b1;
    bus.icache_pmem_address = 32'h0000_0080;
    bus.dcache_pmem_read    = 1'b1;
    bus.dcache_pmem_address = 32'h0000_2000;
    push_exp(1'b1, 1'b1, l_b);
    push_exp(1'b0, 1'b1, l_c);
    wait_cmd();
    chk("tie1_addr", w_t'(bus.pmem_address), w_t'(32'h0000_2000));
    mem_line = l_b;
    mem_burst(0, 4);
    wait_resp();
    wait_cmd();
    chk("tie1_second_addr", w_t'(bus.pmem_address), w_t'(32'h0000_0080));
    mem_line = l_c;
    mem_burst(0, 4);
    wait_resp();

    // Dcache served last, so the next simultaneous pair goes icache first
    bus.dcache_pmem_read    = 1'b1;
    bus.dcache_pmem_address = 32'h0000_2400;
    push_exp(1'b1, 1'b1, l_a);
    wait_cmd();
    mem_line = l_a;
    mem_burst(0, 4);
    wait_resp();
    step();
    bus.icache_pmem_read    = 1'b1;
    bus.icache_pmem_address = 32'h0000_00C0;
    bus.dcache_pmem_read    = 1'b1;
    bus.dcache_pmem_address = 32'h0000_2800;
    push_exp(1'b0, 1'b1, l_b);
    push_exp(1'b1, 1'b1, l_c);
    wait_cmd();
    chk("tie2_addr", w_t'(bus.pmem_address), w_t'(32'h0000_00C0));
    mem_line = l_b;
    mem_burst(0, 4);
    wait_resp();
    wait_cmd();
    chk("tie2_second_addr", w_t'(bus.pmem_address), w_t'(32'h0000_2800));
    mem_line = l_c;
    mem_burst(0, 4);
    wait_resp();

    // Memory stalls 3 cycles between beats 1 and 2
    bus.icache_pmem_read    = 1'b1;
    bus.icache_pmem_address = 32'h0000_0100;
    push_exp(1'b0, 1'b1, l_c);
    wait_cmd();
    mem_line = l_c;
    mem_burst(3, 4);
    wait_resp();
    chk("gap_latency", w_t'(resp_cyc - cmd_cyc), w_t'(7));

    // Reset after beat 2 of an icache read; request stays up and is redone
    bus.icache_pmem_read    = 1'b1;
    bus.icache_pmem_address = 32'h0000_0140;
    wait_cmd();
    mem_line = l_b;
    mem_burst(0, 3);
    rst = 1'b1;
    step();
    chk("mid_rst_read",  w_t'(bus.pmem_read),  w_t'(0));
    chk("mid_rst_write", w_t'(bus.pmem_write), w_t'(0));
    chk("mid_rst_addr",  w_t'(bus.pmem_address), w_t'(0));
    chk("mid_rst_i_resp", w_t'(bus.icache_pmem_resp), w_t'(0));
    chk("mid_rst_d_resp", w_t'(bus.dcache_pmem_resp), w_t'(0));
    chk("mid_rst_i_rdata", bus.icache_pmem_rdata, w_t'(0));
    rst = 1'b0;
    push_exp(1'b0, 1'b1, l_a);
    wait_cmd();
    chk("reissue_addr", w_t'(bus.pmem_address), w_t'(32'h0000_0140));
    mem_line = l_a;
    mem_burst(0, 4);
    wait_resp();

    // Dcache read raised mid icache burst waits for DONE_I -> IDLE
    bus.icache_pmem_read    = 1'b1;
    bus.icache_pmem_address = 32'h0000_0200;
    push_exp(1'b0, 1'b1, l_b);
    wait_cmd();
    bus.dcache_pmem_read    = 1'b1;
    bus.dcache_pmem_address = 32'h0000_3000;
    push_exp(1'b1, 1'b1, l_c);
    mem_line = l_b;
    mem_burst(0, 4);
    wait_resp();
    wait_cmd();
    chk("late_d_addr", w_t'(bus.pmem_address), w_t'(32'h0000_3000));
    chk("late_d_start", w_t'(cmd_cyc - resp_cyc), w_t'(2));
    mem_line = l_c;
    mem_burst(0, 4);
    wait_resp();

    chk("sb_drained", w_t'(sb_q.size()), w_t'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
